bnn_param_loader: RTL

BNN_PARAM_LOADER -- requirements
Module: bnn_param_loader

---
 rtl/bnn_param_loader_pkg.sv | 25 ++
 rtl/bnn_param_loader_if.sv | 44 ++++
 rtl/bnn_byte_serializer.sv | 53 +++++
 rtl/bnn_param_loader.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bnn_param_loader_pkg.sv
// rtl/bnn_param_loader_pkg.sv - shared constants and types for the BNN parameter loader
// Purpose : default chain geometry, total parameter bit count, bit counter
//           width and the loader FSM state encoding.
// Ports   : none (package).
package bnn_param_loader_pkg;

   localparam int DEF_INPUTS    = 8;
   localparam int DEF_BIAS_BITS = 3;
   localparam int DEF_NEURONS   = 4;

   // Each neuron holds INPUTS weight bits followed by BIAS_BITS bias bits.
   function automatic int total_bits(input int neurons, input int inputs, input int bias_bits);
      return neurons * (inputs + bias_bits);
   endfunction

   localparam int TOTAL = total_bits(DEF_NEURONS, DEF_INPUTS, DEF_BIAS_BITS);
   localparam int CNT_W = $clog2(TOTAL + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/bnn_param_loader_if.sv
// rtl/bnn_param_loader_if.sv - host-side byte and inference handshakes of the loader
// Purpose : bundles the configuration byte stream and the inference
//           request/result handshakes seen by the host.
// Signals : cfg_data/cfg_valid/cfg_ready - parameter bytes, MSB first
//           in_vec/in_valid/in_ready     - inference input vector
//           result/result_valid          - sampled neuron outputs and strobe
// Modports: master (host side), slave (loader side).
interface bnn_param_loader_if #(
   parameter int INPUTS  = 8,
   parameter int NEURONS = 4
);

   logic [7:0]         cfg_data;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [INPUTS-1:0]  in_vec;
   logic               in_valid;
   logic               in_ready;
   logic [NEURONS-1:0] result;
   logic               result_valid;

   modport master (
      output cfg_data,
      output cfg_valid,
      input  cfg_ready,
      output in_vec,
      output in_valid,
      input  in_ready,
      input  result,
      input  result_valid
   );

   modport slave (
      input  cfg_data,
      input  cfg_valid,
      output cfg_ready,
      input  in_vec,
      input  in_valid,
      output in_ready,
      output result,
      output result_valid
   );

endinterface

// File: rtl/bnn_byte_serializer.sv
// rtl/bnn_byte_serializer.sv - one-byte parallel-to-serial buffer, MSB first
// Purpose : holds one accepted configuration byte and presents its bits
//           MSB first, advancing one bit per shift request.
// Ports   : clk, rst_n        - clock, asynchronous active-low reset
//           clear             - drop any held bits, become empty
//           load, data        - capture a byte (only issued while empty)
//           shift             - consume the current MSB
//           msb               - bit currently presented
//           empty             - no unconsumed bits remain
module bnn_byte_serializer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       load,
   input  logic [7:0] data,
   input  logic       shift,
   output logic       msb,
   output logic       empty
);

   logic [7:0] sreg_q;
   logic [2:0] cnt_q;
   logic       empty_q;

   // cnt_q is the number of bits left after the one currently at the MSB,
   // so the buffer turns empty on the shift that consumes the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q  <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b1;
      end else if (clear) begin
         sreg_q  <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b1;
      end else if (load) begin
         sreg_q  <= data;
         cnt_q   <= 3'd7;
         empty_q <= 1'b0;
      end else if (shift) begin
         sreg_q <= {sreg_q[6:0], 1'b0};
         if (cnt_q == 3'd0) begin
            empty_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q - 3'd1;
         end
      end
   end

   assign msb   = sreg_q[7];
   assign empty = empty_q;

endmodule

// File: rtl/bnn_param_loader.sv
// rtl/bnn_param_loader.sv - serial parameter loader and inference sequencer for a BNN neuron chain
// Purpose : streams TOTAL configuration bits from host bytes into a
//           daisy-chained neuron array, then runs inference transactions
//           (register input vector, sample neuron outputs one cycle later).
// Ports   : clk, rst_n        - clock, asynchronous active-low reset
//           start            - pulse requesting a parameter reload
//           setup, param_bit - shift enable and serial bit into the chain
//           neuron_in        - registered vector broadcast to all neurons
//           axons            - neuron outputs (combinational from neuron_in)
//           loaded           - a complete parameter load has finished
//           bus              - host byte / inference handshakes (slave)
module bnn_param_loader
   import bnn_param_loader_pkg::*;
#(
   parameter int INPUTS    = DEF_INPUTS,
   parameter int BIAS_BITS = DEF_BIAS_BITS,
   parameter int NEURONS   = DEF_NEURONS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               setup,
   output logic               param_bit,
   output logic [INPUTS-1:0]  neuron_in,
   input  logic [NEURONS-1:0] axons,
   output logic               loaded,
   bnn_param_loader_if.slave  bus
);

   localparam int TOT = total_bits(NEURONS, INPUTS, BIAS_BITS);
   // Counter is never narrower than the one sized for the default chain.
   localparam int CW  = (TOT > TOTAL) ? $clog2(TOT + 1) : CNT_W;
   localparam logic [CW-1:0] CNT_FULL = CW'(TOT);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               loaded_q, loaded_d;

   logic               ser_empty;
   logic               ser_msb;
   logic               ser_clear;
   logic               byte_load;
   logic               cfg_ready;
   logic               shift;
   logic               done;
   logic               reload;

   logic               in_ready;
   logic               accept;
   logic               pend_q;
   logic               result_valid_q;
   logic [INPUTS-1:0]  neuron_in_q;
   logic [NEURONS-1:0] result_q;

   bnn_byte_serializer u_ser (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (ser_clear),
      .load  (byte_load),
      .data  (bus.cfg_data),
      .shift (shift),
      .msb   (ser_msb),
      .empty (ser_empty)
   );

   always_comb begin
      reload    = start && (state_q != LOAD);
      cfg_ready = (state_q == LOAD) && ser_empty;
      byte_load = cfg_ready && bus.cfg_valid;
      shift     = (state_q == LOAD) && !ser_empty && (cnt_q != '0);
      done      = shift && (cnt_q == CNT_ONE);
      // Entering RUN throws away whatever is left of the final byte.
      ser_clear = reload || done;
      in_ready  = (state_q == RUN) && !pend_q;
      // A reload request in the same cycle wins over the input handshake.
      accept    = in_ready && bus.in_valid && !start;

      state_d  = state_q;
      cnt_d    = cnt_q;
      loaded_d = loaded_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = LOAD;
               cnt_d    = CNT_FULL;
               loaded_d = 1'b0;
            end
         end
         LOAD: begin
            if (shift) begin
               cnt_d = cnt_q - CNT_ONE;
               if (done) begin
                  state_d  = RUN;
                  loaded_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (start) begin
               state_d  = LOAD;
               cnt_d    = CNT_FULL;
               loaded_d = 1'b0;
            end
         end
         default: begin
            state_d  = IDLE;
            cnt_d    = '0;
            loaded_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         loaded_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         loaded_q <= loaded_d;
      end
   end

   // Inference: vector registered on the accept edge, axons sampled on the
   // following edge while in_ready is held low for that one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q         <= 1'b0;
         result_valid_q <= 1'b0;
         neuron_in_q    <= '0;
         result_q       <= '0;
      end else begin
         pend_q         <= accept;
         result_valid_q <= pend_q;
         if (accept) begin
            neuron_in_q <= bus.in_vec;
         end
         if (pend_q) begin
            result_q <= axons;
         end
      end
   end

   assign setup            = shift;
   assign param_bit        = shift & ser_msb;
   assign loaded           = loaded_q;
   assign neuron_in        = neuron_in_q;
   assign bus.cfg_ready    = cfg_ready;
   assign bus.in_ready     = in_ready;
   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;

endmodule
